// File: rtl/leitor_rom_estatisticas.sv
// leitor_rom_estatisticas: walks a synchronous-read ROM from address 0 and
// accumulates minimum, maximum, sum and count of the elements that come
// before the first sentinel word, or of all words if no sentinel is present.
//
// Handshake: Inicio is a request sampled on a rising edge. It is accepted
// only when the block is not scanning (Ocupado=0). Ocupado stays high while
// the scan runs. Pronto is a level that means Minimo/Maximo/Soma/Contagem
// are valid, and it stays high until the next accepted Inicio. The result
// outputs only change on the edge that completes a scan.
module leitor_rom_estatisticas #(
  parameter int                       LARGURA_DADOS = 8,
  parameter int                       LARGURA_END   = 9,
  parameter logic [LARGURA_DADOS-1:0] SENTINELA     = 8'hFF
) (
  input  logic                                 CLK,
  input  logic                                 Reset,
  input  logic                                 Inicio,
  input  logic [LARGURA_DADOS-1:0]             Dados,
  output logic [LARGURA_END-1:0]               Endereco,
  output logic [LARGURA_DADOS-1:0]             Minimo,
  output logic [LARGURA_DADOS-1:0]             Maximo,
  output logic [LARGURA_DADOS+LARGURA_END-1:0] Soma,
  output logic [LARGURA_END:0]                 Contagem,
  output logic                                 Ocupado,
  output logic                                 Pronto,
  output logic [1:0]                           Estado
);

  localparam int                 PROFUNDIDADE = 2 ** LARGURA_END;
  localparam logic [LARGURA_END:0] CNT_MAX    = (LARGURA_END+1)'(PROFUNDIDADE);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    VARRE     = 2'd1,
    CONCLUIDO = 2'd2
  } estado_t;

  estado_t estado;

  // Working accumulators; only copied to the outputs when a scan completes.
  logic [LARGURA_DADOS-1:0]             acc_min;
  logic [LARGURA_DADOS-1:0]             acc_max;
  logic [LARGURA_DADOS+LARGURA_END-1:0] acc_soma;
  logic [LARGURA_END:0]                 acc_cnt;

  logic [LARGURA_DADOS-1:0]             prox_min;
  logic [LARGURA_DADOS-1:0]             prox_max;
  logic [LARGURA_DADOS+LARGURA_END-1:0] prox_soma;
  logic [LARGURA_END:0]                 prox_cnt;

  assign Estado = estado;

  // Accumulator values if the element currently on Dados is consumed.
  always_comb begin
    prox_min  = (Dados < acc_min) ? Dados : acc_min;
    prox_max  = (Dados > acc_max) ? Dados : acc_max;
    prox_soma = acc_soma + {{LARGURA_END{1'b0}}, Dados};
    prox_cnt  = acc_cnt + (LARGURA_END+1)'(1);
  end

  // Scan sequencer: address generation, accumulation and result publishing.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      estado   <= OCIOSO;
      Endereco <= '0;
      Minimo   <= '0;
      Maximo   <= '0;
      Soma     <= '0;
      Contagem <= '0;
      Ocupado  <= 1'b0;
      Pronto   <= 1'b0;
      acc_min  <= '1;
      acc_max  <= '0;
      acc_soma <= '0;
      acc_cnt  <= '0;
    end else begin
      case (estado)
        OCIOSO, CONCLUIDO: begin
          // Endereco sits at 0 here, so ROM[0] is already in flight when
          // the start edge arrives and the next edge can consume it.
          Endereco <= '0;
          if (Inicio) begin
            estado   <= VARRE;
            Endereco <= (LARGURA_END)'(1);
            Ocupado  <= 1'b1;
            Pronto   <= 1'b0;
            acc_min  <= '1;
            acc_max  <= '0;
            acc_soma <= '0;
            acc_cnt  <= '0;
          end
        end

        VARRE: begin
          if (Dados == SENTINELA) begin
            // Sentinel ends the list without being counted. An empty list
            // reports 0 for both extremes rather than the seed values.
            estado   <= CONCLUIDO;
            Endereco <= '0;
            Minimo   <= (acc_cnt == '0) ? '0 : acc_min;
            Maximo   <= (acc_cnt == '0) ? '0 : acc_max;
            Soma     <= acc_soma;
            Contagem <= acc_cnt;
            Ocupado  <= 1'b0;
            Pronto   <= 1'b1;
          end else begin
            acc_min  <= prox_min;
            acc_max  <= prox_max;
            acc_soma <= prox_soma;
            acc_cnt  <= prox_cnt;
            Endereco <= Endereco + (LARGURA_END)'(1);
            if (prox_cnt == CNT_MAX) begin
              // Whole ROM consumed with no sentinel; include this element.
              estado   <= CONCLUIDO;
              Endereco <= '0;
              Minimo   <= prox_min;
              Maximo   <= prox_max;
              Soma     <= prox_soma;
              Contagem <= prox_cnt;
              Ocupado  <= 1'b0;
              Pronto   <= 1'b1;
            end
          end
        end

        default: begin
          estado   <= OCIOSO;
          Endereco <= '0;
          Ocupado  <= 1'b0;
          Pronto   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leitor_rom_estatisticas.sv
// Bench for leitor_rom_estatisticas: behavioural ROM, list-level reference
// model, directed scenarios plus randomized ROM contents.
module tb_leitor_rom_estatisticas;

  localparam int DEPTH = 512;

  logic        CLK;
  logic        Reset;
  logic        Inicio;
  logic [7:0]  Dados;
  logic [8:0]  Endereco;
  logic [7:0]  Minimo;
  logic [7:0]  Maximo;
  logic [16:0] Soma;
  logic [9:0]  Contagem;
  logic        Ocupado;
  logic        Pronto;
  logic [1:0]  Estado;

  int n_checks = 0;
  int n_errors = 0;

  // Results of the previous completed scan (held during a new scan).
  int prev_min = 0, prev_max = 0, prev_sum = 0, prev_cnt = 0;

  logic [7:0] rom [DEPTH];

  leitor_rom_estatisticas dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .Inicio   (Inicio),
    .Dados    (Dados),
    .Endereco (Endereco),
    .Minimo   (Minimo),
    .Maximo   (Maximo),
    .Soma     (Soma),
    .Contagem (Contagem),
    .Ocupado  (Ocupado),
    .Pronto   (Pronto),
    .Estado   (Estado)
  );

  // Clock and synchronous-read ROM (one cycle latency).
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) Dados <= rom[Endereco];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: statistics of the list up to the first sentinel.
  task automatic model(output int n, output int mn, output int mx, output int sm);
    n = 0; mn = 0; mx = 0; sm = 0;
    while (n < DEPTH && rom[n] != 8'hFF) begin
      if (n == 0 || rom[n] < mn) mn = rom[n];
      if (n == 0 || rom[n] > mx) mx = rom[n];
      sm += rom[n];
      n++;
    end
  endtask

  task automatic fill_rom(input int v);
    for (int i = 0; i < DEPTH; i++) rom[i] = v[7:0];
  endtask

  task automatic load_list(input int vals[$]);
    fill_rom(8'hFF);
    foreach (vals[i]) rom[i] = vals[i][7:0];
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_end"}, Endereco, 0);
    check({tag, "_min"}, Minimo, 0);
    check({tag, "_max"}, Maximo, 0);
    check({tag, "_soma"}, Soma, 0);
    check({tag, "_cnt"}, Contagem, 0);
    check({tag, "_ocup"}, Ocupado, 0);
    check({tag, "_pronto"}, Pronto, 0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CLK);
    Reset = 1'b1;
    repeat (cycles) @(posedge CLK);
    #1;
    check_zero("reset");
    @(negedge CLK);
    Reset = 1'b0;
    prev_min = 0; prev_max = 0; prev_sum = 0; prev_cnt = 0;
  endtask

  // Start a scan, optionally holding Inicio for `hold` extra edges, and
  // verify address walk, held outputs, latency and final results.
  task automatic run_scan(input string tag, input int hold);
    int n, mn, mx, sm, lat, k;
    bit done;
    model(n, mn, mx, sm);
    lat = (n == DEPTH) ? DEPTH : n + 1;
    @(negedge CLK);
    Inicio = 1'b1;
    @(posedge CLK);
    #1;
    check({tag, "_start_ocup"}, Ocupado, 1);
    check({tag, "_start_pronto"}, Pronto, 0);
    check({tag, "_start_end"}, Endereco, 1);
    check({tag, "_hold_min"}, Minimo, prev_min);
    check({tag, "_hold_max"}, Maximo, prev_max);
    check({tag, "_hold_soma"}, Soma, prev_sum);
    check({tag, "_hold_cnt"}, Contagem, prev_cnt);
    k = 0;
    done = 1'b0;
    while (!done && k < 600) begin
      @(negedge CLK);
      Inicio = (k < hold);
      @(posedge CLK);
      #1;
      k++;
      if (Pronto) done = 1'b1;
      else begin
        check({tag, "_walk_end"}, Endereco, (k + 1) % DEPTH);
        check({tag, "_walk_ocup"}, Ocupado, 1);
        check({tag, "_walk_soma_held"}, Soma, prev_sum);
      end
    end
    Inicio = 1'b0;
    check({tag, "_latency"}, k, lat);
    check({tag, "_min"}, Minimo, mn);
    check({tag, "_max"}, Maximo, mx);
    check({tag, "_soma"}, Soma, sm);
    check({tag, "_cnt"}, Contagem, n);
    check({tag, "_end0"}, Endereco, 0);
    check({tag, "_ocup0"}, Ocupado, 0);
    prev_min = mn; prev_max = mx; prev_sum = sm; prev_cnt = n;
    // Pronto is a level held while idle.
    @(posedge CLK);
    #1;
    check({tag, "_pronto_held"}, Pronto, 1);
    check({tag, "_idle_end"}, Endereco, 0);
  endtask

  initial begin
    int lista1[$];
    int q[$];
    int len, k;
    lista1 = '{10, 2, 7, 12, 25, 31, 47, 3};
    Reset  = 1'b1;
    Inicio = 1'b0;
    fill_rom(8'hFF);

    do_reset(3);

    // Example list: min 2, max 47, sum 137, count 8.
    load_list(lista1);
    run_scan("lista1", 0);
    check("lista1_abs_soma", Soma, 137);

    // Empty list.
    fill_rom(8'hFF);
    run_scan("vazia", 0);

    // Full ROM without sentinel.
    fill_rom(8'hFE);
    run_scan("cheia", 0);
    check("cheia_abs_soma", Soma, 130048);
    check("cheia_abs_cnt", Contagem, 512);

    // Reset in the middle of a scan, then a clean rescan.
    load_list(lista1);
    @(negedge CLK);
    Inicio = 1'b1;
    @(posedge CLK);
    #1;
    k = 0;
    while (Endereco != 9'd4 && k < 20) begin
      @(negedge CLK);
      Inicio = 1'b0;
      @(posedge CLK);
      #1;
      k++;
    end
    check("midreset_reach4", Endereco, 4);
    do_reset(1);
    run_scan("pos_reset", 0);

    // Inicio held during the scan, then a second identical scan.
    run_scan("inicio_longo", 5);
    run_scan("repete", 0);

    // Reset and Inicio together: reset wins, block stays idle.
    @(negedge CLK);
    Reset  = 1'b1;
    Inicio = 1'b1;
    @(posedge CLK);
    #1;
    check_zero("rst_inicio");
    @(negedge CLK);
    Reset  = 1'b0;
    Inicio = 1'b0;
    @(posedge CLK);
    #1;
    check("rst_inicio_ocup_after", Ocupado, 0);
    check("rst_inicio_end_after", Endereco, 0);
    prev_min = 0; prev_max = 0; prev_sum = 0; prev_cnt = 0;

    // Randomized short lists with values below the sentinel.
    repeat (6) begin
      q = {};
      len = $urandom_range(0, 30);
      for (int i = 0; i < len; i++) q.push_back($urandom_range(0, 254));
      load_list(q);
      run_scan("rand_curta", $urandom_range(0, 3));
    end

    // Randomized full-range ROM: the first FF ends the list.
    repeat (3) begin
      for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom_range(0, 255));
      run_scan("rand_rom", 0);
    end

    // Randomized ROM with no sentinel at all.
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom_range(0, 254));
    run_scan("rand_sem_sent", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
